bcd_convert_16dec: RTL and testbench
====================================

// Module: bcd_convert_16dec
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble).
//  Converts an unsigned WIDTH-bit value into 16 packed BCD digits.
//  The output `data` connects directly to the 64-bit `data` input of the labkit
//  hex dot-matrix display driver, so the display shows 16 decimal digits.
//  The result is held stable between conversions, so the display's asynchronous
//  sampling never sees a partial result.
// PARAMETERS
//  WIDTH  48  bit width of `value`; legal range 1..53 (2^53-1 < 10^16, so no overflow)
// PORTS
//  clock_27mhz  in   1      system clock; all state updates on its rising edge
//  reset        in   1      synchronous, active-high
//  start        in   1      request a conversion of `value`; sampled only in IDLE
//  value        in   WIDTH  unsigned binary operand; sampled on the accepting edge only
//  busy         out  1      high whenever state != IDLE
//  done         out  1      one-cycle pulse; `data` holds the new result in that cycle
//  data         out  64     16 BCD digits; [63:60] is the most significant digit
// BEHAVIOUR
//  Reset (synchronous, active-high, clock_27mhz) gives:
//   - state=IDLE, busy=0, done=0, data=64'h0
//   - all internal shift, scratch and counter registers cleared
//   - reset has priority over every other input
//  FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE:
//   - On an edge with start=1: bin <= value, bcd <= 0, cnt <= WIDTH, go to SHIFT.
//   - With start=0: hold.
//  SHIFT (one bit per cycle):
//   - Correction: every 4-bit digit of bcd that is >= 5 has 3 added (all 16 in parallel).
//   - Shift: {bcd,bin} <= {corrected_bcd,bin} << 1.
//   - cnt <= cnt-1; when cnt==1 on this edge, go to DONE.
//   - Exactly WIDTH SHIFT cycles.
//  DONE:
//   - data <= bcd, done=1, go to IDLE.
//   - The DONE cycle is one cycle; busy is still 1 during it.
//  Latency: start accepted at edge k -> data updated and done=1 after edge k+WIDTH+1.
//  Next start is accepted at the earliest at edge k+WIDTH+2, i.e. the first IDLE cycle.
//  start while busy (SHIFT or DONE) is ignored; it is not queued.
//  A change on `value` after acceptance has no effect on the result in flight.
//  data changes only in the DONE cycle or on reset; otherwise it holds the last result.
//  Internal widths:
//   - bcd register is 64 bits; bin shift register is WIDTH bits.
//   - cnt is 6 bits; it never wraps (loaded with WIDTH <= 53, stops at 1).
//   - Each digit's correction is 4-bit modulo add; a digit >= 5 plus 3 is 8..12, so no carry leaves the digit.
//  Reset during SHIFT or DONE aborts the conversion:
//   - no done pulse
//   - data returns to 0
//   - the next conversion needs a new start.
//  Every data nibble is 0..9 at all times (the display also renders A-F, but this block never produces them).
// TESTING
//  1. Reset, then start with value=0:
//     - done after exactly 49 cycles (WIDTH=48), data=64'h0, busy high 48+1 cycles.
//  2. value=12345:
//     - data=64'h0000_0000_0001_2345, done is a single-cycle pulse.
//  3. value=48'hFFFF_FFFF_FFFF (281474976710655):
//     - data=64'h0281_4749_7671_0655.
//  4. value=9999999, then while busy pulse start with value=1 and change `value`:
//     - data=64'h0000_0000_0999_9999, only one done pulse.
//  5. Assert reset mid-SHIFT (cycle 20):
//     - busy=0, done stays 0, data=0.
//     - Then start with value=42 -> data=64'h42 after 49 cycles.
//  6. Back-to-back conversions: start in the first IDLE cycle after done, value=7 then 100:
//     - data=64'h7 then 64'h100.
//     - data is stable between the two done pulses.

Source files
------------

// File: rtl/bcd_convert_16dec.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// Converts an unsigned WIDTH-bit operand into 16 packed BCD digits, one
// operand bit per clock. The published result only changes when a conversion
// completes or on reset, so a display sampling it asynchronously never sees
// a partially converted value.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; operand is captured on the accepting edge
// ST_SHIFT | one correct-and-shift step per cycle, WIDTH cycles total
// ST_DONE  | copy the scratch BCD into data and raise done for one cycle
module bcd_convert_16dec #(
  parameter int WIDTH = 48
) (
  input  logic             clock_27mhz,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [63:0]      data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit count for one conversion; WIDTH <= 53 always fits in 6 bits.
  localparam logic [5:0] CNT_LOAD = 6'(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic             load_en;
  logic             shift_en;
  logic             latch_en;
  logic [WIDTH-1:0] bin;
  logic [63:0]      bcd;
  logic [63:0]      bcd_adj;
  logic [5:0]       cnt;

  // State register; reset wins over every other input.
  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so it is never queued.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt == 6'd1) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State-decoded controls for the datapath and the busy flag.
  always_comb begin
    busy     = 1'b0;
    load_en  = 1'b0;
    shift_en = 1'b0;
    latch_en = 1'b0;
    case (state)
      ST_IDLE: begin
        load_en = start;
      end
      ST_SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
      end
      ST_DONE: begin
        busy     = 1'b1;
        latch_en = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Add 3 to every digit >= 5 before the shift; a corrected digit is 8..12,
  // so the 4-bit add never carries into the neighbouring digit.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 16; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Scratch shift registers and bit counter.
  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (load_en) begin
      bin <= value;
      bcd <= '0;
      cnt <= CNT_LOAD;
    end else if (shift_en) begin
      bcd <= {bcd_adj[62:0], bin[WIDTH-1]};
      bin <= bin << 1;
      cnt <= cnt - 6'd1;
    end
  end

  // Published result and completion pulse; data holds until the next latch.
  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      data <= '0;
      done <= 1'b0;
    end else begin
      done <= latch_en;
      if (latch_en) begin
        data <= bcd;
      end
    end
  end

endmodule

// File: tb/tb_bcd_convert_16dec.sv
// Directed bench for bcd_convert_16dec with hand-computed BCD results.
module tb_bcd_convert_16dec;

  localparam int WIDTH = 48;

  logic             clock_27mhz;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] value;
  logic             busy;
  logic             done;
  logic [63:0]      data;

  int n_checks;
  int n_errors;

  bcd_convert_16dec #(.WIDTH(WIDTH)) dut (
    .clock_27mhz(clock_27mhz),
    .reset      (reset),
    .start      (start),
    .value      (value),
    .busy       (busy),
    .done       (done),
    .data       (data)
  );

  initial clock_27mhz = 1'b0;
  always #5 clock_27mhz = ~clock_27mhz;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic bit digits_ok(input logic [63:0] d);
    for (int i = 0; i < 16; i++) begin
      if (d[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Issue start at a falling edge, then wait (bounded) for done.
  // lat counts cycles after the accepting edge; busy_cyc counts busy samples.
  task automatic conv(input logic [WIDTH-1:0] v, output int lat, output int busy_cyc);
    start = 1'b1;
    value = v;
    @(negedge clock_27mhz);
    start = 1'b0;
    lat = 0;
    busy_cyc = 0;
    while (!done && lat < 200) begin
      if (busy) busy_cyc++;
      @(negedge clock_27mhz);
      lat++;
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] v;
    logic [63:0]      bcd;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat;
    int bc;
    int pulses;
    logic [63:0] held;

    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (3) @(negedge clock_27mhz);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_data", data, 64'h0);
    reset = 1'b0;
    @(negedge clock_27mhz);

    // Zero operand: latency and busy span.
    conv('0, lat, bc);
    chk("zero_lat", 64'(lat), 64'(WIDTH + 1));
    chk("zero_busy", 64'(bc), 64'(WIDTH + 1));
    chk("zero_data", data, 64'h0);
    chk("zero_busy_at_done", 64'(busy), 64'd0);
    @(negedge clock_27mhz);

    // Single-cycle done pulse.
    conv(48'd12345, lat, bc);
    chk("d12345_data", data, 64'h0000_0000_0001_2345);
    @(negedge clock_27mhz);
    chk("d12345_pulse", 64'(done), 64'd0);
    chk("d12345_hold", data, 64'h0000_0000_0001_2345);

    // Directed table including the full-scale operand and digit roll-overs.
    vecs.push_back('{48'hFFFF_FFFF_FFFF, 64'h0281_4749_7671_0655});
    vecs.push_back('{48'd9,              64'h0000_0000_0000_0009});
    vecs.push_back('{48'd10,             64'h0000_0000_0000_0010});
    vecs.push_back('{48'd99999,          64'h0000_0000_0009_9999});
    vecs.push_back('{48'd100000,         64'h0000_0000_0010_0000});
    vecs.push_back('{48'h8000_0000_0000, 64'h0140_7374_8835_5328});
    vecs.push_back('{48'h5AF3_107A_4000, 64'h0100_0000_0000_0000});
    foreach (vecs[i]) begin
      conv(vecs[i].v, lat, bc);
      chk($sformatf("tab%0d_lat", i), 64'(lat), 64'(WIDTH + 1));
      chk($sformatf("tab%0d_data", i), data, vecs[i].bcd);
      chk($sformatf("tab%0d_digits", i), 64'(digits_ok(data)), 64'd1);
      @(negedge clock_27mhz);
    end

    // start while busy (in SHIFT and in DONE) and value changes are ignored.
    start = 1'b1;
    value = 48'd9999999;
    @(negedge clock_27mhz);
    start = 1'b0;
    lat = 0;
    pulses = 0;
    while (lat < 120) begin
      if (lat == 5) begin
        start = 1'b1;
        value = 48'd1;
      end else if (lat == 6) begin
        start = 1'b0;
        value = 48'd55;
      end else if (lat == WIDTH) begin
        start = 1'b1;
        value = 48'd3;
      end else if (lat == WIDTH + 1) begin
        start = 1'b0;
        chk("busy_ign_data", data, 64'h0000_0000_0999_9999);
      end
      if (done) pulses++;
      @(negedge clock_27mhz);
      lat++;
    end
    chk("busy_ign_pulses", 64'(pulses), 64'd1);
    chk("busy_ign_hold", data, 64'h0000_0000_0999_9999);

    // Reset mid-SHIFT aborts the conversion.
    start = 1'b1;
    value = 48'd777;
    @(negedge clock_27mhz);
    start = 1'b0;
    repeat (20) @(negedge clock_27mhz);
    reset = 1'b1;
    @(negedge clock_27mhz);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_data", data, 64'h0);
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      if (done || busy) pulses++;
      @(negedge clock_27mhz);
    end
    chk("abort_quiet", 64'(pulses), 64'd0);
    conv(48'd42, lat, bc);
    chk("after_abort_lat", 64'(lat), 64'(WIDTH + 1));
    chk("after_abort_data", data, 64'h42);
    @(negedge clock_27mhz);

    // Back-to-back: second start in the done cycle of the first.
    conv(48'd7, lat, bc);
    chk("b2b_first", data, 64'h7);
    held = data;
    conv(48'd100, lat, bc);
    chk("b2b_lat", 64'(lat), 64'(WIDTH + 1));
    chk("b2b_second", data, 64'h100);

    // data stable between done pulses of a further back-to-back run.
    start = 1'b1;
    value = 48'd65535;
    @(negedge clock_27mhz);
    start = 1'b0;
    pulses = 0;
    lat = 0;
    while (!done && lat < 200) begin
      if (data !== 64'h100) pulses++;
      @(negedge clock_27mhz);
      lat++;
    end
    chk("stable_between", 64'(pulses), 64'd0);
    chk("stable_final", data, 64'h0000_0000_0006_5535);
    chk("stable_prev", held, 64'h7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
